// File: rtl/mux_sel_serializer_pkg.sv
// Shared constants for the byte/bit serializer family.
// Holds the state encoding and word width so a later deserializer can reuse them.
package mux_sel_serializer_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_sel_serializer_mux_8x1.sv
// 8:1 bit select built from a tree of 2:1 muxes.
// Purely combinational, zero latency, no flow control.
// Select bit 0 steers the leaf level, bit 2 steers the root.
module mux_2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module mux_8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);
  logic [3:0] lvl0;
  logic [1:0] lvl1;

  for (genvar g = 0; g < 4; g++) begin : g_lvl0
    mux_2 u_m (.a(i[2*g]), .b(i[2*g+1]), .sel(s[0]), .y(lvl0[g]));
  end

  for (genvar g = 0; g < 2; g++) begin : g_lvl1
    mux_2 u_m (.a(lvl0[2*g]), .b(lvl0[2*g+1]), .sel(s[1]), .y(lvl1[g]));
  end

  mux_2 u_root (.a(lvl1[0]), .b(lvl1[1]), .sel(s[2]), .y(y));
endmodule

// File: rtl/mux_sel_serializer.sv
// Accepts a byte via valid/ready and emits it one bit per accepted output beat.
// Latency: first bit on y the cycle after acceptance; back-to-back words have no bubble.
// Backpressure: y_ready=0 freezes y/s/y_last; i_ready only opens in IDLE or on the last beat.
module mux_sel_serializer
  import mux_sel_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] i,
  input  logic              i_valid,
  output logic              i_ready,
  output logic              y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              y_last,
  output logic [SEL_W-1:0]  s
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  cnt, cnt_d;
  logic              cnt_at_last;
  logic              load;

  assign cnt_at_last = (cnt == 3'd7);
  assign y_valid     = (state_q == ST_SHIFT);
  assign y_last      = y_valid & cnt_at_last;
  assign i_ready     = ~rst & ((state_q == ST_IDLE) | (y_valid & cnt_at_last & y_ready));
  assign load        = i_valid & i_ready;

  // Select parks at 0 when idle so y shows data_q[0] regardless of bit order.
  assign s = !y_valid ? 3'd0 : (MSB_FIRST ? (3'd7 - cnt) : cnt);

  mux_8x1 u_mux (
    .i (data_q),
    .s (s),
    .y (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          data_d  = i;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (y_ready) begin
          if (!cnt_at_last) begin
            cnt_d = cnt + 3'd1;
          end else if (load) begin
            data_d = i;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Drives LSB-first and MSB-first instances with identical stimulus and checks
// every cycle against a queue-of-pending-beats model of the serializer.
module tb_mux_sel_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i;
  logic       i_valid;
  logic       y_ready;

  logic       l_i_ready, l_y, l_y_valid, l_y_last;
  logic [2:0] l_s;
  logic       m_i_ready, m_y, m_y_valid, m_y_last;
  logic [2:0] m_s;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] w;
    int         idx;
  } beat_t;

  beat_t      q[$];
  logic [7:0] last_word;
  int         loads;

  always #5 clk = ~clk;

  mux_sel_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(l_i_ready),
    .y(l_y), .y_valid(l_y_valid), .y_ready(y_ready), .y_last(l_y_last), .s(l_s)
  );

  mux_sel_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(m_i_ready),
    .y(m_y), .y_valid(m_y_valid), .y_ready(y_ready), .y_last(m_y_last), .s(m_s)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances with the model's view of the current cycle.
  task automatic check_now();
    logic       e_rdy, e_vld, e_last, e_ly, e_my;
    logic [2:0] e_ls, e_ms;
    logic [7:0] w;
    int         k;
    e_rdy = !rst && (q.size() == 0 || (q.size() == 1 && y_ready));
    if (q.size() > 0) begin
      w      = q[0].w;
      k      = q[0].idx;
      e_vld  = 1'b1;
      e_last = (k == 7);
      e_ly   = w[k];
      e_ls   = 3'(k);
      e_my   = w[7-k];
      e_ms   = 3'(7 - k);
    end else begin
      e_vld  = 1'b0;
      e_last = 1'b0;
      e_ly   = last_word[0];
      e_my   = last_word[0];
      e_ls   = 3'd0;
      e_ms   = 3'd0;
    end
    chk("lsb_i_ready", {7'd0, l_i_ready}, {7'd0, e_rdy});
    chk("lsb_y_valid", {7'd0, l_y_valid}, {7'd0, e_vld});
    chk("lsb_y_last",  {7'd0, l_y_last},  {7'd0, e_last});
    chk("lsb_y",       {7'd0, l_y},       {7'd0, e_ly});
    chk("lsb_s",       {5'd0, l_s},       {5'd0, e_ls});
    chk("msb_i_ready", {7'd0, m_i_ready}, {7'd0, e_rdy});
    chk("msb_y_valid", {7'd0, m_y_valid}, {7'd0, e_vld});
    chk("msb_y_last",  {7'd0, m_y_last},  {7'd0, e_last});
    chk("msb_y",       {7'd0, m_y},       {7'd0, e_my});
    chk("msb_s",       {5'd0, m_s},       {5'd0, e_ms});
  endtask

  // One clock: check mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic       e_rdy, do_load, do_beat;
    logic [7:0] i_cap;
    #3;
    check_now();
    e_rdy   = !rst && (q.size() == 0 || (q.size() == 1 && y_ready));
    do_load = i_valid && e_rdy;
    do_beat = !rst && (q.size() > 0) && y_ready;
    i_cap   = i;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      last_word = 8'h00;
    end else begin
      if (do_beat) void'(q.pop_front());
      if (do_load) begin
        for (int k = 0; k < 8; k++) q.push_back('{w: i_cap, idx: k});
        last_word = i_cap;
        loads++;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    i_valid = 1'b0;
    y_ready = 1'b1;
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    int start_loads;
    rst       = 1'b1;
    i         = 8'h00;
    i_valid   = 1'b1;
    y_ready   = 1'b1;
    last_word = 8'h00;
    loads     = 0;

    // Reset state, with i_valid high to show it is ignored.
    @(posedge clk); #1;
    cycle();
    cycle();
    rst     = 1'b0;
    i_valid = 1'b0;
    idle_cycles(2);

    // Single word 8'hC1, y_ready held high.
    i = 8'hC1; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    idle_cycles(10);

    // Backpressure during beat 3.
    i = 8'hC1; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    cycle(); cycle();
    y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_hold_s", {5'd0, l_s}, 8'd2);
    end
    idle_cycles(10);

    // Back-to-back: i_valid held through the handover to the second word.
    i = 8'hC1; i_valid = 1'b1;
    start_loads = loads;
    cycle();
    i = 8'h0F;
    for (int c = 0; c < 20 && loads < start_loads + 2; c++) cycle();
    chk("b2b_second_load", 8'(loads - start_loads), 8'd2);
    idle_cycles(12);

    // Asynchronous reset mid-word at beat 4.
    i = 8'hC1; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    cycle(); cycle(); cycle();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_lsb_y_valid", {7'd0, l_y_valid}, 8'd0);
    chk("arst_lsb_s",       {5'd0, l_s},       8'd0);
    chk("arst_msb_y_valid", {7'd0, m_y_valid}, 8'd0);
    chk("arst_i_ready",     {7'd0, l_i_ready}, 8'd0);
    q.delete();
    last_word = 8'h00;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    i = 8'h0F; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    idle_cycles(10);

    // Input isolation: i toggles while 8'h00 is shifting.
    i = 8'h00; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    i = 8'hFF;
    idle_cycles(10);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      i       = 8'($urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      y_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_cycles(12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
